// File: rtl/zeroriscy_instr_mem_responder.sv
// Instruction-fetch responder: req/gnt/rvalid protocol, fixed grant-to-rvalid latency, outstanding limit.
// Define ZERORISCY_IMEM_STALL_EN to add an LFSR-driven pseudo-random grant stall.
module zeroriscy_instr_mem_responder #(
    parameter int         MEM_WORDS       = 1024,
    parameter int         LATENCY         = 1,
    parameter int         MAX_OUTSTANDING = 2,
    parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         instr_req_i,
    input  logic [31:0]                  instr_addr_i,
    output logic                         instr_gnt_o,
    output logic                         instr_rvalid_o,
    output logic [31:0]                  instr_rdata_o,
    input  logic                         init_we_i,
    input  logic [$clog2(MEM_WORDS)-1:0] init_addr_i,
    input  logic [31:0]                  init_wdata_i,
    output logic                         busy_o
);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [IDX_W-1:0] req_idx;
    logic             unused_addr;
    logic             stall;
    logic             grant;
    logic             response;

    logic [LATENCY-1:0] valid_reg;
    logic [IDX_W-1:0]   idx_reg [LATENCY];
    logic               last_valid_next;
    logic [IDX_W-1:0]   last_idx_next;

    logic [CNT_W-1:0] outstanding_reg;
    logic [CNT_W-1:0] outstanding_next;
    logic [31:0]      rdata_reg;
    logic [31:0]      mem [MEM_WORDS];

    // Only the word index matters; upper bits alias, so fetches wrap around the array.
    assign req_idx     = instr_addr_i[IDX_W+1:2];
    assign unused_addr = ^{instr_addr_i[31:IDX_W+2], instr_addr_i[1:0]};

    // No bypass: a slot freed by this cycle's response is only usable next cycle.
    assign grant    = rst_n & instr_req_i & (outstanding_reg < MAX_CNT) & ~stall;
    assign response = rst_n & valid_reg[LATENCY-1];

    generate
        for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
            logic             stage_valid_in;
            logic [IDX_W-1:0] stage_idx_in;

            if (gi == 0) begin : g_head
                assign stage_valid_in = grant;
                assign stage_idx_in   = req_idx;
            end else begin : g_body
                assign stage_valid_in = valid_reg[gi-1];
                assign stage_idx_in   = idx_reg[gi-1];
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    valid_reg[gi] <= 1'b0;
                end else begin
                    valid_reg[gi] <= stage_valid_in;
                end
            end

            always_ff @(posedge clk) begin
                idx_reg[gi] <= stage_idx_in;
            end
        end

        // The array is read on the edge that moves an entry into the last stage,
        // so data and rvalid appear together.
        if (LATENCY == 1) begin : g_last_from_grant
            assign last_valid_next = grant;
            assign last_idx_next   = req_idx;
        end else begin : g_last_from_pipe
            assign last_valid_next = valid_reg[LATENCY-2];
            assign last_idx_next   = idx_reg[LATENCY-2];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (init_we_i) begin
            mem[init_addr_i] <= init_wdata_i;
        end
    end

    // Read-before-write: a backdoor write on the sampling edge is not seen by this read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_reg <= '0;
        end else if (last_valid_next) begin
            rdata_reg <= mem[last_idx_next];
        end
    end

    always_comb begin
        outstanding_next = outstanding_reg;
        case ({grant, response})
            2'b10:   outstanding_next = outstanding_reg + CNT_W'(1);
            2'b01:   outstanding_next = outstanding_reg - CNT_W'(1);
            default: outstanding_next = outstanding_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outstanding_reg <= '0;
        end else begin
            outstanding_reg <= outstanding_next;
        end
    end

`ifdef ZERORISCY_IMEM_STALL_EN
    logic [7:0] lfsr_reg;
    logic [7:0] lfsr_next;

    // Fibonacci LFSR, taps 8,6,5,4.
    assign lfsr_next = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
    assign stall     = (lfsr_reg[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= lfsr_next;
        end
    end
`else
    logic [7:0] unused_seed;
    assign unused_seed = LFSR_SEED;
    assign stall       = 1'b0;
`endif

    assign instr_gnt_o    = grant;
    assign instr_rvalid_o = response;
    assign instr_rdata_o  = rst_n ? rdata_reg : 32'h0;
    assign busy_o         = rst_n & (outstanding_reg != '0);

    gnt_needs_req: assert property (@(posedge clk) instr_gnt_o |-> instr_req_i);
    outstanding_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        outstanding_reg <= MAX_CNT);
    no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        response |-> (outstanding_reg != '0));
endmodule

// File: tb/tb_zeroriscy_instr_mem_responder.sv
// Two responder configurations (LATENCY 1 / 3) driven by one stimulus stream; each is
// scored against a queue model of the fetch protocol (grant rule, in-order timed responses).
`timescale 1ns/1ps
module tb_zeroriscy_instr_mem_responder;
    localparam int         MEM_WORDS = 1024;
    localparam int         IDX_W     = 10;
    localparam logic [7:0] SEED      = 8'hA5;

    typedef struct {
        int          idx;
        int          due;
        logic [31:0] data;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             instr_req;
    logic [31:0]      instr_addr;
    logic             init_we;
    logic [IDX_W-1:0] init_addr;
    logic [31:0]      init_wdata;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] mem_model [MEM_WORDS];
    logic [7:0]  lfsr_model = 8'h0;

    always #5 clk = ~clk;

    task automatic check(input int cfg, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL L%0d %s at cycle %0d: got %h, expected %h", cfg, name, cyc, act, exp);
        end
    endtask

    // Bookkeeping of what the clock edge commits: cycle count, backdoor writes, LFSR.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (init_we) mem_model[init_addr] = init_wdata;
        if (!rst_n) lfsr_model = SEED;
        else lfsr_model = {lfsr_model[6:0], ^(lfsr_model & 8'b1011_1000)};
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
        localparam int LAT  = (gi == 0) ? 1 : 3;
        localparam int MAXO = (gi == 0) ? 1 : 2;

        logic        gnt;
        logic        rvalid;
        logic        busy;
        logic [31:0] rdata;
        exp_t        exp_q[$];
        int          due_q[$];

        zeroriscy_instr_mem_responder #(
            .MEM_WORDS(MEM_WORDS),
            .LATENCY(LAT),
            .MAX_OUTSTANDING(MAXO),
            .LFSR_SEED(SEED)
        ) dut (
            .clk(clk),
            .rst_n(rst_n),
            .instr_req_i(instr_req),
            .instr_addr_i(instr_addr),
            .instr_gnt_o(gnt),
            .instr_rvalid_o(rvalid),
            .instr_rdata_o(rdata),
            .init_we_i(init_we),
            .init_addr_i(init_addr),
            .init_wdata_i(init_wdata),
            .busy_o(busy)
        );

        // Reference: a request is granted iff fewer than MAXO earlier grants are still
        // awaiting (or receiving) their response and no stall is active.
        initial forever begin
            logic stall_m;
            logic exp_gnt;
            exp_t e;
            @(negedge clk);
            while (due_q.size() > 0 && due_q[0] < cyc) void'(due_q.pop_front());
            stall_m = 1'b0;
`ifdef ZERORISCY_IMEM_STALL_EN
            stall_m = (lfsr_model[1:0] == 2'b00);
`endif
            exp_gnt = rst_n && instr_req && (due_q.size() < MAXO) && !stall_m;
            check(LAT, "gnt", 32'(gnt), 32'(exp_gnt));
            check(LAT, "busy", 32'(busy), 32'(rst_n && due_q.size() > 0));
            if (!rst_n) begin
                due_q.delete();
                exp_q.delete();
            end else if (exp_gnt) begin
                due_q.push_back(cyc + LAT);
                e.idx  = int'((instr_addr >> 2) % MEM_WORDS);
                e.due  = cyc + LAT;
                e.data = 32'h0;
                exp_q.push_back(e);
            end
            // Data is fixed by memory contents just before the edge preceding the response.
            foreach (exp_q[i]) begin
                if (exp_q[i].due == cyc + 1) exp_q[i].data = mem_model[exp_q[i].idx];
            end
        end

        // Monitor: every rvalid must match the oldest pending grant, on its due cycle.
        initial forever begin
            exp_t e;
            @(negedge clk);
            if (!rst_n) begin
                check(LAT, "rvalid_in_reset", 32'(rvalid), 32'h0);
                check(LAT, "rdata_in_reset", rdata, 32'h0);
            end else if (rvalid) begin
                if (exp_q.size() == 0) begin
                    check(LAT, "spurious_rvalid", 32'(rvalid), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check(LAT, "rvalid_cycle", 32'(cyc), 32'(e.due));
                    check(LAT, "rdata", rdata, e.data);
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                check(LAT, "missing_rvalid", 32'(rvalid), 32'h1);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic drive(input logic r, input logic [31:0] a, input logic w, input int wa,
                         input logic [31:0] wd);
        instr_req  = r;
        instr_addr = a;
        init_we    = w;
        init_addr  = IDX_W'(wa);
        init_wdata = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, $urandom, 1'b0, 0, 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        rst_n      = 1'b0;
        instr_req  = 1'b0;
        instr_addr = 32'h0;
        init_we    = 1'b0;
        init_addr  = '0;
        init_wdata = 32'h0;
        @(posedge clk);
        #1;
        // Preload under reset; random phase only reads words 0..63.
        for (int w = 0; w < 64; w++) drive(1'b0, 32'h0, 1'b1, w, $urandom);
        drive(1'b0, 32'h0, 1'b1, 3, 32'hDEADBEEF);
        drive(1'b0, 32'h0, 1'b1, 0, 32'h0000_0013);
        drive(1'b0, 32'h0, 1'b1, 5, 32'h1111_1111);
        rst_n = 1'b1;
        idle(2);

        // Single fetch of word 3.
        drive(1'b1, 32'h0000_000C, 1'b0, 0, 32'h0);
        idle(5);

        // Throttling: request held across the outstanding limit.
        for (int k = 0; k < 8; k++) drive(1'b1, 32'(4 * (k % 3)), 1'b0, 0, 32'h0);
        idle(8);

        // Wrap: byte address 0x1000 aliases word 0.
        drive(1'b1, 32'h0000_1000, 1'b0, 0, 32'h0);
        idle(5);

        // Backdoor write committed on the grant edge, then on the following edge.
        drive(1'b1, 32'h0000_0014, 1'b1, 5, 32'h2222_2222);
        idle(6);
        drive(1'b0, 32'h0, 1'b1, 5, 32'h1111_1111);
        idle(2);
        drive(1'b1, 32'h0000_0014, 1'b0, 0, 32'h0);
        drive(1'b0, 32'h0, 1'b1, 5, 32'h2222_2222);
        idle(6);

        // Reset while two requests are in flight, then an immediate new request.
        drive(1'b1, 32'h0000_000C, 1'b0, 0, 32'h0);
        drive(1'b1, 32'h0000_0010, 1'b0, 0, 32'h0);
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 0, 32'h0);
        rst_n = 1'b1;
        drive(1'b1, 32'h0000_0014, 1'b0, 0, 32'h0);
        idle(6);

        // Request held continuously for 64 cycles.
        for (int k = 0; k < 64; k++) drive(1'b1, 32'(4 * (k % 64)), 1'b0, 0, 32'h0);
        idle(6);

        // Random traffic with aliased upper bits, backdoor writes and occasional resets.
        for (int n = 0; n < 600; n++) begin
            a = ($urandom << 12) | (32'($urandom_range(0, 63)) << 2) | ($urandom & 32'h3);
            rst_n = ($urandom_range(0, 99) != 0);
            drive($urandom_range(0, 3) != 0, a, $urandom_range(0, 7) == 0,
                  int'($urandom_range(0, 63)), $urandom);
        end
        rst_n = 1'b1;
        idle(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
